// File: rtl/simd_lane_alu_pipe.sv
// Two-stage pipelined SIMD integer lane unit: packed add/sub, saturating add/sub,
// min/max, compares and per-element shifts on 8/16/32/64-bit elements.
module simd_lane_alu_pipe #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned TAGW  = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_op,
   input  logic [1:0]       in_esz,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [TAGW-1:0]  in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_res,
   output logic [TAGW-1:0]  out_tag
);

   // One element computed in a 64-bit container; a and b arrive zero-extended.
   function automatic logic [63:0] lane_op(input logic [3:0]  op,
                                           input logic [1:0]  esz,
                                           input logic [63:0] a,
                                           input logic [63:0] b);
      logic [6:0]         ew;
      logic [5:0]         msb;
      logic [63:0]        mask, smax, smin;
      logic [64:0]        sum;
      logic [63:0]        add_r, sub_r, shl_r, shr_r, sar_r, res;
      logic signed [63:0] sar_src;
      logic [5:0]         cnt;
      logic               sa, sb, carry, borrow, ltu, gtu, lts, gts, eq;
      logic               ovf_add, ovf_sub;
      ew      = 7'd8 << esz;
      msb     = 6'(ew - 7'd1);
      mask    = (esz == 2'd3) ? '1 : ((64'd1 << ew) - 64'd1);
      smax    = mask >> 1;
      smin    = mask ^ smax;
      sum     = {1'b0, a} + {1'b0, b};
      add_r   = sum[63:0] & mask;
      carry   = sum[ew];
      sub_r   = (a - b) & mask;
      sa      = a[msb];
      sb      = b[msb];
      ltu     = a < b;
      gtu     = b < a;
      borrow  = ltu;
      eq      = a == b;
      // Differing signs decide a signed compare; equal signs reduce to unsigned.
      lts     = (sa != sb) ? sa : ltu;
      gts     = (sa != sb) ? sb : gtu;
      ovf_add = (sa == sb) && (add_r[msb] != sa);
      ovf_sub = (sa != sb) && (sub_r[msb] != sa);
      cnt     = b[5:0] & msb;
      shl_r   = (a << cnt) & mask;
      shr_r   = a >> cnt;
      sar_src = sa ? (a | ~mask) : a;
      sar_r   = 64'(sar_src >>> cnt) & mask;
      case (op)
         4'd0:    res = add_r;
         4'd1:    res = sub_r;
         4'd2:    res = carry ? mask : add_r;
         4'd3:    res = ovf_add ? (sa ? smin : smax) : add_r;
         4'd4:    res = borrow ? '0 : sub_r;
         4'd5:    res = ovf_sub ? (sa ? smin : smax) : sub_r;
         4'd6:    res = gtu ? b : a;
         4'd7:    res = gts ? b : a;
         4'd8:    res = ltu ? b : a;
         4'd9:    res = lts ? b : a;
         4'd10:   res = eq  ? mask : '0;
         4'd11:   res = ltu ? mask : '0;
         4'd12:   res = lts ? mask : '0;
         4'd13:   res = shl_r;
         4'd14:   res = shr_r;
         default: res = sar_r;
      endcase
      return res;
   endfunction

   logic             s1_valid_q, s1_valid_d;
   logic [3:0]       s1_op_q, s1_op_d;
   logic [1:0]       s1_esz_q, s1_esz_d;
   logic [WIDTH-1:0] s1_a_q, s1_a_d;
   logic [WIDTH-1:0] s1_b_q, s1_b_d;
   logic [TAGW-1:0]  s1_tag_q, s1_tag_d;
   logic             s2_valid_q, s2_valid_d;
   logic [WIDTH-1:0] s2_res_q, s2_res_d;
   logic [TAGW-1:0]  s2_tag_q, s2_tag_d;

   logic             s2_adv, s1_adv, accept;
   logic [WIDTH-1:0] s1_res;

   always_comb begin
      s2_adv   = ~s2_valid_q | out_ready;
      s1_adv   = s1_valid_q & s2_adv;
      in_ready = (~s1_valid_q | s2_adv) & ~flush & ~rst;
      accept   = in_valid & in_ready;
   end

   always_comb begin
      s1_res = '0;
      case (s1_esz_q)
         2'd0:
            for (int unsigned i = 0; i < WIDTH / 8; i++)
               s1_res[i*8 +: 8] = 8'(lane_op(s1_op_q, 2'd0, 64'(s1_a_q[i*8 +: 8]),
                                             64'(s1_b_q[i*8 +: 8])));
         2'd1:
            for (int unsigned i = 0; i < WIDTH / 16; i++)
               s1_res[i*16 +: 16] = 16'(lane_op(s1_op_q, 2'd1, 64'(s1_a_q[i*16 +: 16]),
                                                64'(s1_b_q[i*16 +: 16])));
         2'd2:
            for (int unsigned i = 0; i < WIDTH / 32; i++)
               s1_res[i*32 +: 32] = 32'(lane_op(s1_op_q, 2'd2, 64'(s1_a_q[i*32 +: 32]),
                                                64'(s1_b_q[i*32 +: 32])));
         2'd3:
            for (int unsigned i = 0; i < WIDTH / 64; i++)
               s1_res[i*64 +: 64] = lane_op(s1_op_q, 2'd3, s1_a_q[i*64 +: 64],
                                            s1_b_q[i*64 +: 64]);
      endcase
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_op_d    = s1_op_q;
      s1_esz_d   = s1_esz_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s1_tag_d   = s1_tag_q;
      s2_valid_d = s2_valid_q;
      s2_res_d   = s2_res_q;
      s2_tag_d   = s2_tag_q;

      if (accept) begin
         s1_valid_d = 1'b1;
         s1_op_d    = in_op;
         s1_esz_d   = in_esz;
         s1_a_d     = in_a;
         s1_b_d     = in_b;
         s1_tag_d   = in_tag;
      end else if (s1_adv) begin
         s1_valid_d = 1'b0;
      end

      if (s2_adv)
         s2_valid_d = s1_valid_q;
      if (s1_adv) begin
         s2_res_d = s1_res;
         s2_tag_d = s1_tag_q;
      end

      if (flush) begin
         s1_valid_d = 1'b0;
         s2_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_op_q    <= '0;
         s1_esz_q   <= '0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_tag_q   <= '0;
         s2_valid_q <= 1'b0;
         s2_res_q   <= '0;
         s2_tag_q   <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_op_q    <= s1_op_d;
         s1_esz_q   <= s1_esz_d;
         s1_a_q     <= s1_a_d;
         s1_b_q     <= s1_b_d;
         s1_tag_q   <= s1_tag_d;
         s2_valid_q <= s2_valid_d;
         s2_res_q   <= s2_res_d;
         s2_tag_q   <= s2_tag_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign out_res   = s2_res_q;
   assign out_tag   = s2_tag_q;

endmodule

// File: tb/tb_simd_lane_alu_pipe.sv
// Directed bench for simd_lane_alu_pipe: vector table for the ALU functions,
// hand-written sequences for streaming, stall, flush and reset.
module tb_simd_lane_alu_pipe;

   localparam int unsigned WIDTH = 64;
   localparam int unsigned TAGW  = 9;
   localparam int NV = 21;

   logic             clk = 1'b0;
   logic             rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic [3:0]       in_op;
   logic [1:0]       in_esz;
   logic [WIDTH-1:0] in_a, in_b, out_res;
   logic [TAGW-1:0]  in_tag, out_tag;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [3:0]  op;
      logic [1:0]  esz;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] exp;
   } vec_t;

   vec_t vecs [NV];

   simd_lane_alu_pipe #(.WIDTH(WIDTH), .TAGW(TAGW)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_esz(in_esz), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_res(out_res), .out_tag(out_tag)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] op, input logic [1:0] esz,
                        input logic [63:0] a, input logic [63:0] b, input int tag);
      in_valid = 1'b1;
      in_op    = op;
      in_esz   = esz;
      in_a     = a;
      in_b     = b;
      in_tag   = TAGW'(tag);
   endtask

   initial begin
      vecs[0]  = '{4'd2,  2'd0, 64'h0000_0000_0000_01F0, 64'h0000_0000_0000_0020, 64'h0000_0000_0000_01FF};
      vecs[1]  = '{4'd0,  2'd0, 64'h0000_0000_0000_01F0, 64'h0000_0000_0000_0020, 64'h0000_0000_0000_0110};
      vecs[2]  = '{4'd5,  2'd1, 64'h0000_0000_0000_8000, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_8000};
      vecs[3]  = '{4'd3,  2'd1, 64'h0000_0000_0000_7FFF, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_7FFF};
      vecs[4]  = '{4'd4,  2'd1, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0002, 64'h0000_0000_0000_0000};
      vecs[5]  = '{4'd15, 2'd2, 64'h0000_0000_8000_0010, 64'h0000_0000_0000_0024, 64'h0000_0000_F800_0001};
      vecs[6]  = '{4'd14, 2'd2, 64'h0000_0000_8000_0010, 64'h0000_0000_0000_0024, 64'h0000_0000_0800_0001};
      vecs[7]  = '{4'd12, 2'd2, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0000, 64'h0000_0000_FFFF_FFFF};
      vecs[8]  = '{4'd0,  2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0000};
      vecs[9]  = '{4'd2,  2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF};
      vecs[10] = '{4'd6,  2'd0, 64'h0102_0304_8080_FF00, 64'h0201_0403_7F80_00FF, 64'h0101_0303_7F80_0000};
      vecs[11] = '{4'd7,  2'd0, 64'h0102_0304_8080_FF00, 64'h0201_0403_7F80_00FF, 64'h0101_0303_8080_FFFF};
      vecs[12] = '{4'd8,  2'd0, 64'h0102_0304_8080_FF00, 64'h0201_0403_7F80_00FF, 64'h0202_0404_8080_FFFF};
      vecs[13] = '{4'd9,  2'd0, 64'h0102_0304_8080_FF00, 64'h0201_0403_7F80_00FF, 64'h0202_0404_7F80_0000};
      vecs[14] = '{4'd10, 2'd1, 64'h1234_5678_0000_FFFF, 64'h1234_5679_0000_FFFE, 64'hFFFF_0000_FFFF_0000};
      vecs[15] = '{4'd11, 2'd1, 64'h0001_8000_0000_7FFF, 64'h0002_7FFF_0000_8000, 64'hFFFF_0000_0000_FFFF};
      vecs[16] = '{4'd13, 2'd0, 64'h0101_0101_0101_0101, 64'h0001_0203_0708_0910, 64'h0102_0408_8001_0201};
      vecs[17] = '{4'd15, 2'd3, 64'h8000_0000_0000_0000, 64'h0000_0000_0000_007F, 64'hFFFF_FFFF_FFFF_FFFF};
      vecs[18] = '{4'd3,  2'd1, 64'h8000_7FFF_4000_C000, 64'h8000_0001_4000_C000, 64'h8000_7FFF_7FFF_8000};
      vecs[19] = '{4'd4,  2'd2, 64'h0000_0005_FFFF_FFFF, 64'h0000_0006_0000_0001, 64'h0000_0000_FFFF_FFFE};
      vecs[20] = '{4'd1,  2'd0, 64'h0000_0000_0000_0500, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_05FF};

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_op = '0; in_esz = '0; in_a = '0; in_b = '0; in_tag = '0;

      // Reset behaviour
      repeat (3) @(negedge clk);
      #1 chk("rst_in_ready_low", 64'(in_ready), 64'd0);
      @(negedge clk); #1;
      rst = 1'b0;
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_res", out_res, 64'd0);
      chk("rst_out_tag", 64'(out_tag), 64'd0);
      chk("rst_in_ready_high", 64'(in_ready), 64'd1);

      // Vector table, one op at a time, fixed two-edge latency
      for (int i = 0; i < NV; i++) begin
         @(negedge clk); #1;
         chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'd1);
         drive(vecs[i].op, vecs[i].esz, vecs[i].a, vecs[i].b, i);
         @(negedge clk); #1;
         in_valid = 1'b0;
         chk($sformatf("vec%0d_early_valid", i), 64'(out_valid), 64'd0);
         @(negedge clk); #1;
         chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
         chk($sformatf("vec%0d_res", i), out_res, vecs[i].exp);
         chk($sformatf("vec%0d_tag", i), 64'(out_tag), 64'(i));
      end

      // Back-to-back stream, alternating op and element size
      for (int c = 0; c < 11; c++) begin
         @(negedge clk); #1;
         if (c >= 2 && c <= 9) begin
            chk($sformatf("stream%0d_valid", c - 2), 64'(out_valid), 64'd1);
            chk($sformatf("stream%0d_tag", c - 2), 64'(out_tag), 64'(c - 2));
            chk($sformatf("stream%0d_res", c - 2), out_res,
                ((c - 2) % 2 == 0) ? 64'(c - 1) : 64'(c - 3));
         end else begin
            chk($sformatf("stream_idle%0d_valid", c), 64'(out_valid), 64'd0);
         end
         if (c < 8) begin
            chk($sformatf("stream%0d_in_ready", c), 64'(in_ready), 64'd1);
            if (c % 2 == 0) drive(4'd0, 2'd0, 64'(c), 64'd1, c);
            else            drive(4'd1, 2'd3, 64'(c), 64'd1, c);
         end else begin
            in_valid = 1'b0;
         end
      end

      // Stall: out_ready low for 4 cycles with 3 ops offered
      begin
         int nxt = 0;
         int got = 0;
         for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            out_ready = (c >= 4);
            #1;
            if (c == 1) chk("stall_bubble_in_ready", 64'(in_ready), 64'd1);
            if (c == 2 || c == 3) begin
               chk($sformatf("stall_full_in_ready_c%0d", c), 64'(in_ready), 64'd0);
               chk($sformatf("stall_hold_valid_c%0d", c), 64'(out_valid), 64'd1);
               chk($sformatf("stall_hold_tag_c%0d", c), 64'(out_tag), 64'd10);
               chk($sformatf("stall_hold_res_c%0d", c), out_res, 64'd11);
            end
            if (out_valid && out_ready) begin
               chk($sformatf("stall_order_tag%0d", got), 64'(out_tag), 64'(10 + got));
               chk($sformatf("stall_order_res%0d", got), out_res, 64'(11 + got));
               got++;
            end
            if (nxt < 3) begin
               drive(4'd0, 2'd0, 64'(10 + nxt), 64'd1, 10 + nxt);
               if (in_ready) nxt++;
            end else begin
               in_valid = 1'b0;
            end
         end
         chk("stall_accepted", 64'(nxt), 64'd3);
         chk("stall_delivered", 64'(got), 64'd3);
      end

      // Flush with both stages full, covering bubble collapse on the way
      @(negedge clk); #1;
      out_ready = 1'b0;
      drive(4'd0, 2'd0, 64'd20, 64'd1, 20);
      @(negedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk); #1;
      chk("flush_s2_valid", 64'(out_valid), 64'd1);
      chk("bubble_collapse_in_ready", 64'(in_ready), 64'd1);
      drive(4'd0, 2'd0, 64'd21, 64'd1, 21);
      @(negedge clk); #1;
      in_valid = 1'b0;
      chk("full_in_ready", 64'(in_ready), 64'd0);
      flush = 1'b1;
      drive(4'd0, 2'd0, 64'd22, 64'd1, 22);
      #1 chk("flush_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk); #1;
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      chk("flush_out_valid", 64'(out_valid), 64'd0);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk); #1;
         chk($sformatf("flush_no_ghost%0d", c), 64'(out_valid), 64'd0);
      end

      // Reset in the middle of a stream
      @(negedge clk); #1;
      drive(4'd0, 2'd0, 64'd30, 64'd1, 30);
      @(negedge clk); #1;
      drive(4'd0, 2'd0, 64'd31, 64'd1, 31);
      @(negedge clk); #1;
      chk("midrst_pre_valid", 64'(out_valid), 64'd1);
      chk("midrst_pre_tag", 64'(out_tag), 64'd30);
      rst = 1'b1;
      drive(4'd0, 2'd0, 64'd32, 64'd1, 32);
      #1 chk("midrst_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk); #1;
      rst = 1'b0; in_valid = 1'b0;
      #1;
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_out_res", out_res, 64'd0);
      chk("midrst_out_tag", 64'(out_tag), 64'd0);
      chk("midrst_in_ready_after", 64'(in_ready), 64'd1);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); #1;
         chk($sformatf("midrst_no_ghost%0d", c), 64'(out_valid), 64'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
